// File: rtl/accum_alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : accum_alu_pkg                                              |
// | Purpose : Operation encodings, FSM state type and seven-segment      |
// |           constants shared by the accumulator ALU and its decoder.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package accum_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Active-low segments: all ones turns every segment off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/accum_alu_hex7seg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hex7seg                                                    |
// | Purpose : One hex nibble to active-low seven-segment image,          |
// |           segment a in bit 0 through segment g in bit 6.             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module hex7seg (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Pure lookup of the glyph for each nibble value.
  always_comb begin
    seg_o = 7'h7F;
    case (digit_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/accum_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : accum_alu                                                  |
// | Purpose : Accumulator ALU (ADD/SUB/MUL/CLR) started by a rising edge |
// |           on go, with shift-add multiply and hex display output.     |
// | Macro   : ACCUM_ALU_SAT_EN - saturating signed ADD/SUB when defined. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module accum_alu #(
  parameter int WIDTH = 8,
  parameter int NDIG  = (WIDTH + 3) / 4
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [WIDTH-1:0]    sw,
  input  logic [1:0]          op,
  input  logic                go,
  output logic [WIDTH-1:0]    acc,
  output logic                carry,
  output logic                ovf,
  output logic                busy,
  output logic [7*NDIG-1:0]   hex
);
  import accum_alu_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e              state_q, state_d;
  logic                go_q;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic                carry_q, carry_d;
  logic                ovf_q, ovf_d;
  logic [WIDTH-1:0]    opnd_q, opnd_d;
  logic [1:0]          opsel_q, opsel_d;
  logic [2*WIDTH-1:0]  mcand_q, mcand_d;
  logic [2*WIDTH-1:0]  prod_q, prod_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                w_start;
  logic [WIDTH:0]      w_sum;
  logic [WIDTH:0]      w_diff;
  logic                w_add_ovf;
  logic                w_sub_ovf;
  logic [WIDTH-1:0]    w_add_res;
  logic [WIDTH-1:0]    w_sub_res;
  logic [2*WIDTH-1:0]  w_prod_nxt;

  // go history is forced high in reset so a held request cannot fire.
  assign w_start = go & ~go_q;

  assign w_sum      = {1'b0, acc_q} + {1'b0, opnd_q};
  assign w_diff     = {1'b0, acc_q} - {1'b0, opnd_q};
  assign w_add_ovf  = (acc_q[WIDTH-1] == opnd_q[WIDTH-1]) && (w_sum[WIDTH-1] != acc_q[WIDTH-1]);
  assign w_sub_ovf  = (acc_q[WIDTH-1] != opnd_q[WIDTH-1]) && (w_diff[WIDTH-1] != acc_q[WIDTH-1]);
  assign w_prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);

`ifdef ACCUM_ALU_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  // Overflow can only push away from the accumulator's own sign.
  assign w_add_res = w_add_ovf ? (acc_q[WIDTH-1] ? SAT_MIN : SAT_MAX) : w_sum[WIDTH-1:0];
  assign w_sub_res = w_sub_ovf ? (acc_q[WIDTH-1] ? SAT_MIN : SAT_MAX) : w_diff[WIDTH-1:0];
`else
  assign w_add_res = w_sum[WIDTH-1:0];
  assign w_sub_res = w_diff[WIDTH-1:0];
`endif

  // Next-state logic of the control FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_start) state_d = (op == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_MUL:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: capture operands on start, commit results only on completion.
  always_comb begin
    acc_d    = acc_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    opnd_d   = opnd_q;
    opsel_d  = opsel_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_start) begin
          opnd_d   = sw;
          opsel_d  = op;
          mcand_d  = {{WIDTH{1'b0}}, acc_q};
          mplier_d = sw;
          prod_d   = '0;
          cnt_d    = '0;
        end
      end
      ST_EXEC: begin
        case (opsel_q)
          OP_ADD: begin
            acc_d   = w_add_res;
            carry_d = w_sum[WIDTH];
            ovf_d   = w_add_ovf;
          end
          OP_SUB: begin
            acc_d   = w_sub_res;
            carry_d = w_diff[WIDTH];
            ovf_d   = w_sub_ovf;
          end
          OP_CLR: begin
            acc_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end
          default: ;
        endcase
      end
      ST_MUL: begin
        prod_d   = w_prod_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          acc_d   = w_prod_nxt[WIDTH-1:0];
          ovf_d   = |w_prod_nxt[2*WIDTH-1:WIDTH];
          carry_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_q  <= ST_IDLE;
      go_q     <= 1'b1;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      opnd_q   <= '0;
      opsel_q  <= OP_ADD;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      go_q     <= go;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      opnd_q   <= opnd_d;
      opsel_q  <= opsel_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc   = acc_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q != ST_IDLE);

  // One decoder per digit; digits beyond the accumulator width stay blank.
  for (genvar d = 0; d < NDIG; d++) begin : g_digit
    if (d * 4 >= WIDTH) begin : g_blank
      assign hex[7*d +: 7] = SEG_BLANK;
    end else begin : g_dec
      logic [3:0] w_nib;
      for (genvar k = 0; k < 4; k++) begin : g_bit
        if (d * 4 + k < WIDTH) begin : g_live
          assign w_nib[k] = acc_q[d*4+k];
        end else begin : g_pad
          assign w_nib[k] = 1'b0;
        end
      end
      hex7seg u_hex7seg (
        .digit_i (w_nib),
        .seg_o   (hex[7*d +: 7])
      );
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accum_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_accum_alu                                               |
// | Purpose : Self-checking bench for accum_alu (WIDTH 8, 12 and 5).     |
// | Macro   : ACCUM_ALU_SAT_EN - expectations follow the saturating ADD/SUB. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_accum_alu;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        Resetn = 1'b1;
  logic [7:0]  sw = '0;
  logic [1:0]  op = '0;
  logic        go = 1'b1;
  logic [7:0]  acc;
  logic        carry, ovf, busy;
  logic [13:0] hex;

  logic [11:0] sw12 = '0;
  logic [1:0]  op12 = '0;
  logic        go12 = 1'b0;
  logic [11:0] acc12;
  logic        carry12, ovf12, busy12;
  logic [27:0] hex12;

  logic [4:0]  sw5 = '0;
  logic [1:0]  op5 = '0;
  logic        go5 = 1'b0;
  logic [4:0]  acc5;
  logic        carry5, ovf5, busy5;
  logic [13:0] hex5;

  int checks = 0;
  int failures = 0;

  int m_acc = 0;
  int m_carry = 0;
  int m_ovf = 0;

  always #5 clk = ~clk;

  accum_alu #(.WIDTH(8)) u_dut (
    .Clock(clk), .Resetn(Resetn), .sw(sw), .op(op), .go(go),
    .acc(acc), .carry(carry), .ovf(ovf), .busy(busy), .hex(hex)
  );

  accum_alu #(.WIDTH(12), .NDIG(4)) u_dut12 (
    .Clock(clk), .Resetn(Resetn), .sw(sw12), .op(op12), .go(go12),
    .acc(acc12), .carry(carry12), .ovf(ovf12), .busy(busy12), .hex(hex12)
  );

  accum_alu #(.WIDTH(5)) u_dut5 (
    .Clock(clk), .Resetn(Resetn), .sw(sw5), .op(op5), .go(go5),
    .acc(acc5), .carry(carry5), .ovf(ovf5), .busy(busy5), .hex(hex5)
  );

  // Glyph for a hex value, segment a in bit 0, active low.
  function automatic logic [6:0] seg(input int v);
    case (v & 15)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Arithmetic reference for one operation on the 8-bit accumulator.
  task automatic model_apply(input int s, input int o);
    int md, half, sa, sb, ss, res;
    md   = 1 << W;
    half = 1 << (W - 1);
    sa = (m_acc >= half) ? m_acc - md : m_acc;
    sb = (s >= half) ? s - md : s;
    case (o)
      0: begin
        m_carry = (m_acc + s >= md) ? 1 : 0;
        ss  = sa + sb;
        res = (m_acc + s) % md;
        m_ovf = (ss > half - 1 || ss < -half) ? 1 : 0;
`ifdef ACCUM_ALU_SAT_EN
        if (m_ovf == 1) res = (ss > 0) ? half - 1 : half;
`endif
        m_acc = res;
      end
      1: begin
        m_carry = (m_acc < s) ? 1 : 0;
        ss  = sa - sb;
        res = (m_acc - s + md) % md;
        m_ovf = (ss > half - 1 || ss < -half) ? 1 : 0;
`ifdef ACCUM_ALU_SAT_EN
        if (m_ovf == 1) res = (ss > 0) ? half - 1 : half;
`endif
        m_acc = res;
      end
      2: begin
        m_ovf   = (m_acc * s >= md) ? 1 : 0;
        m_acc   = (m_acc * s) % md;
        m_carry = 0;
      end
      default: begin
        m_acc = 0; m_carry = 0; m_ovf = 0;
      end
    endcase
  endtask

  // One operation on the 8-bit DUT, checked against the model.
  task automatic run_op(input logic [7:0] s, input logic [1:0] o, input bit poke_go);
    int cyc, exp_busy, old_acc;
    @(negedge clk) go = 1'b0;
    @(negedge clk) begin sw = s; op = o; go = 1'b1; end
    old_acc  = m_acc;
    exp_busy = (o == 2'b10) ? W + 1 : 2;
    model_apply(int'(s), int'(o));
    cyc = 0;
    @(negedge clk);
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 1) begin sw = 8'($urandom); op = 2'($urandom); end
      if (poke_go) go = (cyc % 2 == 1);
      if (cyc < exp_busy) begin
        checks++;
        if (acc !== 8'(old_acc)) begin
          failures++;
          $display("FAIL acc_hold op=%0d cyc=%0d got=%h want=%h", o, cyc, acc, 8'(old_acc));
        end
      end
      @(negedge clk);
    end
    go = 1'b0;
    checks++;
    if (cyc != exp_busy) begin
      failures++;
      $display("FAIL busy_len op=%0d got=%0d want=%0d", o, cyc, exp_busy);
    end
    checks++;
    if (acc !== 8'(m_acc) || carry !== 1'(m_carry) || ovf !== 1'(m_ovf)) begin
      failures++;
      $display("FAIL result op=%0d sw=%h got acc=%h c=%b v=%b want acc=%h c=%0d v=%0d",
               o, s, acc, carry, ovf, 8'(m_acc), m_carry, m_ovf);
    end
    checks++;
    if (hex !== {seg(m_acc >> 4), seg(m_acc)}) begin
      failures++;
      $display("FAIL hex8 got=%h want=%h", hex, {seg(m_acc >> 4), seg(m_acc)});
    end
  endtask

  task automatic test_reset;
    int seen;
    Resetn = 1'b1; go = 1'b1; op = 2'b00; sw = 8'h33;
    repeat (3) @(negedge clk);
    Resetn = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || acc !== 8'h00 || carry !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state busy_cycles=%0d acc=%h c=%b v=%b want 0 00 0 0", seen, acc, carry, ovf);
    end
    go = 1'b0;
    m_acc = 0; m_carry = 0; m_ovf = 0;
  endtask

  task automatic test_add_twice;
    run_op(8'h05, 2'b00, 1'b0);
    run_op(8'h05, 2'b00, 1'b0);
    checks++;
    if (acc !== 8'h0A || carry !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL add_twice got acc=%h c=%b v=%b want 0a 0 0", acc, carry, ovf);
    end
  endtask

  task automatic test_add_ovf;
    run_op(8'h00, 2'b11, 1'b0);
    run_op(8'h7F, 2'b00, 1'b0);
    run_op(8'h01, 2'b00, 1'b0);
    checks++;
`ifdef ACCUM_ALU_SAT_EN
    if (acc !== 8'h7F || ovf !== 1'b1) begin
      failures++;
      $display("FAIL add_sat got acc=%h v=%b want 7f 1", acc, ovf);
    end
`else
    if (acc !== 8'h80 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL add_wrap got acc=%h v=%b want 80 1", acc, ovf);
    end
`endif
  endtask

  task automatic test_sub_borrow;
    run_op(8'h00, 2'b11, 1'b0);
    run_op(8'h03, 2'b00, 1'b0);
    run_op(8'h05, 2'b01, 1'b0);
    checks++;
    if (acc !== 8'hFE || carry !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL sub_borrow got acc=%h c=%b v=%b want fe 1 0", acc, carry, ovf);
    end
  endtask

  task automatic test_mul;
    int seen;
    run_op(8'h00, 2'b11, 1'b0);
    run_op(8'h12, 2'b00, 1'b0);
    run_op(8'h10, 2'b10, 1'b1);
    checks++;
    if (acc !== 8'h20 || ovf !== 1'b1 || carry !== 1'b0) begin
      failures++;
      $display("FAIL mul got acc=%h c=%b v=%b want 20 0 1", acc, carry, ovf);
    end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL no_queue busy_cycles=%0d want 0", seen);
    end
  endtask

  task automatic test_reset_mid_mul;
    int seen;
    run_op(8'h00, 2'b11, 1'b0);
    run_op(8'h12, 2'b00, 1'b0);
    @(negedge clk) go = 1'b0;
    @(negedge clk) begin sw = 8'h10; op = 2'b10; go = 1'b1; end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || acc !== 8'h12) begin
      failures++;
      $display("FAIL mid_mul got busy=%b acc=%h want 1 12", busy, acc);
    end
    Resetn = 1'b1;
    @(negedge clk) Resetn = 1'b0;
    m_acc = 0; m_carry = 0; m_ovf = 0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0 || acc !== 8'h00) seen++;
    end
    checks++;
    if (seen != 0 || carry !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort bad_cycles=%0d acc=%h c=%b v=%b want 0 00 0 0", seen, acc, carry, ovf);
    end
    go = 1'b0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom), 2'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_hex12;
    int cyc;
    @(negedge clk) go12 = 1'b0;
    @(negedge clk) begin sw12 = 12'hABC; op12 = 2'b00; go12 = 1'b1; end
    cyc = 0;
    @(negedge clk);
    while (busy12 === 1'b1 && cyc < 40) begin cyc++; @(negedge clk); end
    go12 = 1'b0;
    checks++;
    if (cyc != 2 || acc12 !== 12'hABC) begin
      failures++;
      $display("FAIL w12_add got cyc=%0d acc=%h want 2 abc", cyc, acc12);
    end
    checks++;
    if (hex12 !== {7'h7F, seg(10), seg(11), seg(12)}) begin
      failures++;
      $display("FAIL hex12 got=%h want=%h", hex12, {7'h7F, seg(10), seg(11), seg(12)});
    end
  endtask

  task automatic test_hex5;
    int v, cyc;
    for (int i = 0; i < 8; i++) begin
      v = (i < 2) ? 15 + i : int'($urandom_range(31, 0));
      for (int step = 0; step < 2; step++) begin
        @(negedge clk) go5 = 1'b0;
        @(negedge clk) begin sw5 = 5'(v); op5 = (step == 0) ? 2'b11 : 2'b00; go5 = 1'b1; end
        cyc = 0;
        @(negedge clk);
        while (busy5 === 1'b1 && cyc < 40) begin cyc++; @(negedge clk); end
        go5 = 1'b0;
      end
      checks++;
      if (acc5 !== 5'(v) || hex5 !== {seg(v >> 4), seg(v)} || hex5[13:7] === 7'h7F) begin
        failures++;
        $display("FAIL hex5 v=%0d got acc=%h hex=%h want hex=%h", v, acc5, hex5, {seg(v >> 4), seg(v)});
      end
    end
  endtask

  initial begin
    test_reset;
    test_add_twice;
    test_add_ovf;
    test_sub_borrow;
    test_mul;
    test_reset_mid_mul;
    test_random;
    test_hex12;
    test_hex5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
